// File: rtl/step_counter_seq_if.sv
// Control/status bundle between the multiplier controller (master) and the step counter (slave).
// The overrun status line exists only when STEP_OVERRUN_EN is defined.
interface step_counter_seq_if #(
  parameter int CNT_W = 5
);
  logic             load;
  logic             en;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             k;
  logic             done_pulse;
`ifdef STEP_OVERRUN_EN
  logic             overrun;
`endif

  modport master (
    output load, en, steps,
    input  count, busy, k, done_pulse
`ifdef STEP_OVERRUN_EN
    , input overrun
`endif
  );

  modport slave (
    input  load, en, steps,
    output count, busy, k, done_pulse
`ifdef STEP_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/step_counter_seq.sv
// Step counter/sequencer for the shift-add multiplier controller: counts qualified steps up to a
// terminal count latched at load. Optional macro STEP_OVERRUN_EN adds a sticky overrun flag.
module step_counter_seq #(
  parameter int MAX_STEPS   = 16,
  parameter int CNT_W       = 5,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  step_counter_seq_if.slave   bus
);

  if ((2 ** CNT_W) <= MAX_STEPS) begin : g_bad_width
    $error("step_counter_seq: CNT_W too narrow for MAX_STEPS");
  end

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_term,  w_term_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_k,     w_k_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic [CNT_W-1:0] w_steps_clamped;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_stray_en;
`ifdef STEP_OVERRUN_EN
  logic             r_overrun, w_overrun_nxt;
`endif

  assign w_steps_clamped = (bus.steps > MAX_C) ? MAX_C : bus.steps;
  assign w_count_inc     = r_count + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_term_nxt  = r_term;
    w_busy_nxt  = r_busy;
    w_k_nxt     = r_k;
    w_pulse_nxt = 1'b0;
    w_stray_en  = 1'b0;
    if (bus.load) begin
      w_term_nxt  = w_steps_clamped;
      w_count_nxt = '0;
      if (w_steps_clamped == '0) begin
        w_state_nxt = S_DONE;
        w_busy_nxt  = 1'b0;
        w_k_nxt     = 1'b1;
        // Suppressed if a pulse is already out, so the strobe is never two cycles wide.
        w_pulse_nxt = ~r_pulse;
      end else begin
        w_state_nxt = S_RUN;
        w_busy_nxt  = 1'b1;
        w_k_nxt     = 1'b0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: w_stray_en = bus.en;
        S_RUN: begin
          if (bus.en) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == r_term) begin
              w_state_nxt = S_DONE;
              w_busy_nxt  = 1'b0;
              w_k_nxt     = 1'b1;
              w_pulse_nxt = ~r_pulse;
            end
          end
        end
        S_DONE: begin
          if (AUTO_RELOAD != 0) begin
            // A zero terminal count is already complete, so reload leaves it parked in DONE.
            if (bus.en && (r_term != '0)) begin
              w_state_nxt = S_RUN;
              w_count_nxt = '0;
              w_busy_nxt  = 1'b1;
              w_k_nxt     = 1'b0;
            end
          end else begin
            w_stray_en = bus.en;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef STEP_OVERRUN_EN
  always_comb begin
    w_overrun_nxt = r_overrun;
    if (bus.load)        w_overrun_nxt = 1'b0;
    else if (w_stray_en) w_overrun_nxt = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_term  <= '0;
      r_busy  <= 1'b0;
      r_k     <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_term  <= w_term_nxt;
      r_busy  <= w_busy_nxt;
      r_k     <= w_k_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

`ifdef STEP_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else        r_overrun <= w_overrun_nxt;
  end
  assign bus.overrun = r_overrun;
`else
  logic w_unused;
  assign w_unused = w_stray_en;
`endif

  assign bus.count      = r_count;
  assign bus.busy       = r_busy;
  assign bus.k          = r_k;
  assign bus.done_pulse = r_pulse;

endmodule

// File: tb/tb_step_counter_seq.sv
// Scoreboard bench for step_counter_seq: instance A (AUTO_RELOAD=0) and instance B (AUTO_RELOAD=1).
// Overrun checks are compiled in only when STEP_OVERRUN_EN is defined.
module tb_step_counter_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  step_counter_seq_if #(.CNT_W(5)) ifa ();
  step_counter_seq_if #(.CNT_W(5)) ifb ();

  step_counter_seq #(.MAX_STEPS(16), .CNT_W(5), .AUTO_RELOAD(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  step_counter_seq #(.MAX_STEPS(16), .CNT_W(5), .AUTO_RELOAD(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    string      tag;
    logic [4:0] count;
    logic       busy;
    logic       k;
    logic       pulse;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus on instance sel (0=A, 1=B); the expected post-edge outputs are queued
  // with the stimulus and popped after the edge.
  task automatic cyc(input bit sel, input logic ld, input logic e, input logic [4:0] st,
                     input logic [4:0] ec, input logic eb, input logic ek, input logic ep,
                     input string tag);
    exp_t x;
    ifa.load = 1'b0; ifa.en = 1'b0; ifa.steps = '0;
    ifb.load = 1'b0; ifb.en = 1'b0; ifb.steps = '0;
    if (sel) begin ifb.load = ld; ifb.en = e; ifb.steps = st; end
    else     begin ifa.load = ld; ifa.en = e; ifa.steps = st; end
    x.tag = tag; x.count = ec; x.busy = eb; x.k = ek; x.pulse = ep;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (sel) begin
      check({x.tag, ".count"}, 32'(ifb.count),      32'(x.count));
      check({x.tag, ".busy"},  32'(ifb.busy),       32'(x.busy));
      check({x.tag, ".k"},     32'(ifb.k),          32'(x.k));
      check({x.tag, ".pulse"}, 32'(ifb.done_pulse), 32'(x.pulse));
    end else begin
      check({x.tag, ".count"}, 32'(ifa.count),      32'(x.count));
      check({x.tag, ".busy"},  32'(ifa.busy),       32'(x.busy));
      check({x.tag, ".k"},     32'(ifa.k),          32'(x.k));
      check({x.tag, ".pulse"}, 32'(ifa.done_pulse), 32'(x.pulse));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ifa.load = 1'b0; ifa.en = 1'b0; ifa.steps = '0;
    ifb.load = 1'b0; ifb.en = 1'b0; ifb.steps = '0;
    #3;
    check("rst.count", 32'(ifa.count), 0);
    check("rst.busy",  32'(ifa.busy), 0);
    check("rst.k",     32'(ifa.k), 0);
    check("rst.pulse", 32'(ifa.done_pulse), 0);
    #9 rst_n = 1'b1;

    // idle ignores en
    cyc(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, "idle_en");

    // steps=4 with en held high
    cyc(0, 1, 0, 5'd4, 5'd0, 1, 0, 0, "t1_load");
    for (int unsigned i = 1; i <= 3; i++)
      cyc(0, 0, 1, 5'd0, 5'(i), 1, 0, 0, "t1_run");
    cyc(0, 0, 1, 5'd0, 5'd4, 0, 1, 1, "t1_done");
    for (int unsigned i = 0; i < 10; i++)
      cyc(0, 0, 0, 5'd0, 5'd4, 0, 1, 0, "t1_hold");

    // steps=3 with gapped enables
    cyc(0, 1, 0, 5'd3, 5'd0, 1, 0, 0, "t2_load");
    cyc(0, 0, 1, 5'd0, 5'd1, 1, 0, 0, "t2_e1");
    cyc(0, 0, 0, 5'd0, 5'd1, 1, 0, 0, "t2_e0a");
    cyc(0, 0, 1, 5'd0, 5'd2, 1, 0, 0, "t2_e2");
    cyc(0, 0, 0, 5'd0, 5'd2, 1, 0, 0, "t2_e0b");
    cyc(0, 0, 1, 5'd0, 5'd3, 0, 1, 1, "t2_done");
    cyc(0, 0, 0, 5'd0, 5'd3, 0, 1, 0, "t2_after");

    // zero terminal count
    cyc(0, 1, 0, 5'd0, 5'd0, 0, 1, 1, "t3_load0");
    cyc(0, 0, 0, 5'd0, 5'd0, 0, 1, 0, "t3_after");

    // load with en mid-run restarts
    cyc(0, 1, 0, 5'd4, 5'd0, 1, 0, 0, "t4_load");
    cyc(0, 0, 1, 5'd0, 5'd1, 1, 0, 0, "t4_r1");
    cyc(0, 0, 1, 5'd0, 5'd2, 1, 0, 0, "t4_r2");
    cyc(0, 1, 1, 5'd5, 5'd0, 1, 0, 0, "t4_reload");
    for (int unsigned i = 1; i <= 4; i++)
      cyc(0, 0, 1, 5'd0, 5'(i), 1, 0, 0, "t4_run");
    cyc(0, 0, 1, 5'd0, 5'd5, 0, 1, 1, "t4_done");

    // asynchronous reset mid-run
    cyc(0, 1, 0, 5'd4, 5'd0, 1, 0, 0, "t5_load");
    for (int unsigned i = 1; i <= 3; i++)
      cyc(0, 0, 1, 5'd0, 5'(i), 1, 0, 0, "t5_run");
    rst_n = 1'b0;
    #2;
    check("t5_async.count", 32'(ifa.count), 0);
    check("t5_async.busy",  32'(ifa.busy), 0);
    check("t5_async.k",     32'(ifa.k), 0);
    #3 rst_n = 1'b1;
    cyc(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, "t5_en_after");
    cyc(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, "t5_en_after2");
`ifdef STEP_OVERRUN_EN
    check("t5_ovr_idle", 32'(ifa.overrun), 1);
`endif

    // clamp steps=20 to 16
    cyc(0, 1, 0, 5'd20, 5'd0, 1, 0, 0, "t6_load");
`ifdef STEP_OVERRUN_EN
    check("t6_ovr_clr", 32'(ifa.overrun), 0);
`endif
    for (int unsigned i = 1; i <= 15; i++)
      cyc(0, 0, 1, 5'd0, 5'(i), 1, 0, 0, "t6_run");
    cyc(0, 0, 1, 5'd0, 5'd16, 0, 1, 1, "t6_done");
    cyc(0, 0, 1, 5'd0, 5'd16, 0, 1, 0, "t6_en_done");
`ifdef STEP_OVERRUN_EN
    check("t6_ovr_set", 32'(ifa.overrun), 1);
    cyc(0, 0, 0, 5'd0, 5'd16, 0, 1, 0, "t6_hold");
    check("t6_ovr_sticky", 32'(ifa.overrun), 1);
`endif
    cyc(0, 1, 0, 5'd2, 5'd0, 1, 0, 0, "t6_next_load");
`ifdef STEP_OVERRUN_EN
    check("t6_ovr_load", 32'(ifa.overrun), 0);
`endif

    // auto-reload instance
    cyc(1, 1, 0, 5'd2, 5'd0, 1, 0, 0, "t7_load");
    cyc(1, 0, 1, 5'd0, 5'd1, 1, 0, 0, "t7_r1");
    cyc(1, 0, 1, 5'd0, 5'd2, 0, 1, 1, "t7_done");
    cyc(1, 0, 1, 5'd0, 5'd0, 1, 0, 0, "t7_reload");
    cyc(1, 0, 1, 5'd0, 5'd1, 1, 0, 0, "t7_r1b");
    cyc(1, 0, 1, 5'd0, 5'd2, 0, 1, 1, "t7_done2");
    cyc(1, 0, 0, 5'd0, 5'd2, 0, 1, 0, "t7_hold");
`ifdef STEP_OVERRUN_EN
    check("t7_no_ovr", 32'(ifb.overrun), 0);
`endif

    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
